// File: rtl/mmio_gpio.sv
`default_nettype none
// ============================================================================
// Module   : mmio_gpio
// Brief    : Memory-mapped GPIO with per-pin direction, synchronised inputs
//            and edge-triggered interrupts (write-1-to-clear pending bits).
//            Define GPIO_SET_CLR_EN to add SET/CLR write-only aliases of
//            DATA_OUT at 0x18/0x1C.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_gpio #(
    parameter int          WIDTH       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] RESET_OUT   = 32'h0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req,
    input  logic             we,
    input  logic [7:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rvalid,
    output logic             error,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [7:0] c_ADDR_DATA_OUT = 8'h00;
    localparam logic [7:0] c_ADDR_DIR      = 8'h04;
    localparam logic [7:0] c_ADDR_DATA_IN  = 8'h08;
    localparam logic [7:0] c_ADDR_IRQ_EN   = 8'h0C;
    localparam logic [7:0] c_ADDR_IRQ_PEND = 8'h10;
    localparam logic [7:0] c_ADDR_IRQ_RISE = 8'h14;
    localparam logic [7:0] c_ADDR_SET      = 8'h18;
    localparam logic [7:0] c_ADDR_CLR      = 8'h1C;
    localparam logic [2:0] c_ARM_MAX       = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irq_en;
    logic [WIDTH-1:0] r_irq_pend;
    logic [WIDTH-1:0] r_irq_rise;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_hist;
    logic [2:0]       r_arm;
    logic             r_rvalid;
    logic             r_error;
    logic [31:0]      r_rdata;

    logic             w_aligned;
    logic             w_sel_out, w_sel_dir, w_sel_in, w_sel_en, w_sel_pend, w_sel_rise;
    logic             w_sel_set, w_sel_clr;
    logic             w_err;
    logic             w_wr;
    logic [31:0]      w_rd_val;
    logic [WIDTH-1:0] w_sync_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_armed;
    logic [WIDTH-1:0] w_wdata;
    wire              w_unused_wdata = ^wdata;

    assign w_wdata    = wdata[WIDTH-1:0];
    assign w_aligned  = (addr[1:0] == 2'b00);
    assign w_sel_out  = (addr == c_ADDR_DATA_OUT);
    assign w_sel_dir  = (addr == c_ADDR_DIR);
    assign w_sel_in   = (addr == c_ADDR_DATA_IN);
    assign w_sel_en   = (addr == c_ADDR_IRQ_EN);
    assign w_sel_pend = (addr == c_ADDR_IRQ_PEND);
    assign w_sel_rise = (addr == c_ADDR_IRQ_RISE);
`ifdef GPIO_SET_CLR_EN
    assign w_sel_set  = (addr == c_ADDR_SET);
    assign w_sel_clr  = (addr == c_ADDR_CLR);
`else
    assign w_sel_set  = 1'b0;
    assign w_sel_clr  = 1'b0;
`endif

    // Unmapped, misaligned, write to DATA_IN, or read of a write-only alias.
    assign w_err = !w_aligned
                 | !(w_sel_out | w_sel_dir | w_sel_in | w_sel_en | w_sel_pend
                     | w_sel_rise | w_sel_set | w_sel_clr)
                 | (we & w_sel_in)
                 | (!we & (w_sel_set | w_sel_clr));
    assign w_wr  = req & we & !w_err;

    always_comb begin
        w_rd_val = '0;
        case (addr)
            c_ADDR_DATA_OUT: w_rd_val = 32'(r_data_out);
            c_ADDR_DIR:      w_rd_val = 32'(r_dir);
            c_ADDR_DATA_IN:  w_rd_val = 32'(w_sync_q);
            c_ADDR_IRQ_EN:   w_rd_val = 32'(r_irq_en);
            c_ADDR_IRQ_PEND: w_rd_val = 32'(r_irq_pend);
            c_ADDR_IRQ_RISE: w_rd_val = 32'(r_irq_rise);
            default:         w_rd_val = '0;
        endcase
    end

    // Edge detection stays masked until the synchroniser has flushed its
    // reset zeros, so pins held high through reset never look like a rise.
    assign w_sync_q = r_sync[SYNC_STAGES-1];
    assign w_armed  = (r_arm == c_ARM_MAX);
    assign w_rise   = w_sync_q & ~r_hist;
    assign w_fall   = ~w_sync_q & r_hist;
    assign w_edge   = w_armed ? ((r_irq_rise & w_rise) | (~r_irq_rise & w_fall)) : '0;
    assign w_clr    = (w_wr && w_sel_pend) ? w_wdata : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_data_out <= RESET_OUT[WIDTH-1:0];
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_pend <= '0;
            r_irq_rise <= '0;
            r_hist     <= '0;
            r_arm      <= '0;
            r_rvalid   <= 1'b0;
            r_error    <= 1'b0;
            r_rdata    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync_q;
            if (!w_armed) begin
                r_arm <= r_arm + 3'd1;
            end

            // Set wins over a same-edge write-1-to-clear.
            r_irq_pend <= (r_irq_pend & ~w_clr) | w_edge;

            if (w_wr) begin
                if (w_sel_out)  r_data_out <= w_wdata;
                if (w_sel_dir)  r_dir      <= w_wdata;
                if (w_sel_en)   r_irq_en   <= w_wdata;
                if (w_sel_rise) r_irq_rise <= w_wdata;
                if (w_sel_set)  r_data_out <= r_data_out | w_wdata;
                if (w_sel_clr)  r_data_out <= r_data_out & ~w_wdata;
            end

            r_rvalid <= req;
            r_error  <= req & w_err;
            r_rdata  <= (req && !we && !w_err) ? w_rd_val : '0;
        end
    end

    assign rvalid  = r_rvalid;
    assign error   = r_error;
    assign rdata   = r_rdata;
    assign gpio_o  = r_data_out;
    assign gpio_oe = r_dir;
    assign irq     = |(r_irq_pend & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_mmio_gpio.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_gpio
// Brief    : Self-checking bench for mmio_gpio: directed scenarios plus
//            randomized bus/pin traffic against a sample-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_gpio;

    localparam int W  = 16;
    localparam int SS = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          req;
    logic          we;
    logic [7:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          error;
    logic [W-1:0]  gpio_i;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_oe;
    logic          irq;

    always #5 clk = ~clk;

    mmio_gpio #(
        .WIDTH       (W),
        .SYNC_STAGES (SS),
        .RESET_OUT   (32'h0000_00A5)
    ) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .error   (error),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: registers plus the full history of pin samples taken
    // since reset; synchroniser and edge history are derived by indexing.
    logic [W-1:0] m_out, m_dir, m_en, m_pend, m_rise;
    logic [W-1:0] in_hist[$];
    int           m_n;
    logic         e_rvalid, e_error;
    logic [31:0]  e_rdata;

    function automatic logic [W-1:0] in_at(input int j);
        if (j >= 1 && j <= in_hist.size()) return in_hist[j-1];
        return '0;
    endfunction

    task automatic step();
        logic [W-1:0] cur, prev, ev, clr, rd, wd;
        logic         err;
        if (!resetn) begin
            m_out = W'(32'h00A5); m_dir = '0; m_en = '0; m_pend = '0; m_rise = '0;
            m_n = 0; in_hist.delete();
            e_rvalid = 1'b0; e_error = 1'b0; e_rdata = '0;
        end else begin
            m_n++;
            in_hist.push_back(gpio_i);
            cur  = in_at(m_n - SS);
            prev = in_at(m_n - SS - 1);
            ev   = (m_rise & cur & ~prev) | (~m_rise & ~cur & prev);
            if (m_n < SS + 2) ev = '0;
            clr = '0; rd = '0; err = 1'b0; wd = wdata[W-1:0];
            if (req) begin
                if (addr[1:0] != 2'b00) err = 1'b1;
                else begin
                    case (addr)
                        8'h00: begin rd = m_out;  if (we) m_out  = wd; end
                        8'h04: begin rd = m_dir;  if (we) m_dir  = wd; end
                        8'h08: begin rd = cur;    if (we) err    = 1'b1; end
                        8'h0C: begin rd = m_en;   if (we) m_en   = wd; end
                        8'h10: begin rd = m_pend; if (we) clr    = wd; end
                        8'h14: begin rd = m_rise; if (we) m_rise = wd; end
`ifdef GPIO_SET_CLR_EN
                        8'h18: if (we) m_out = m_out | wd;  else err = 1'b1;
                        8'h1C: if (we) m_out = m_out & ~wd; else err = 1'b1;
`endif
                        default: err = 1'b1;
                    endcase
                end
            end
            e_rvalid = req;
            e_error  = req & err;
            e_rdata  = (req && !we && !err) ? 32'(rd) : 32'h0;
            m_pend   = (m_pend & ~clr) | ev;
        end
        @(posedge clk);
        #1;
        check("rvalid",  32'(rvalid),  32'(e_rvalid));
        check("error",   32'(error),   32'(e_error));
        check("rdata",   rdata,        e_rdata);
        check("gpio_o",  32'(gpio_o),  32'(m_out));
        check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
        check("irq",     32'(irq),     32'(|(m_pend & m_en)));
    endtask

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        step();
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] addrs [10];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'h20};
        resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; gpio_i = '0;

        // Reset state and first read
        idle(2);
        check("rst_gpio_o", 32'(gpio_o), 32'h00A5);
        check("rst_oe",     32'(gpio_oe), 32'h0);
        resetn = 1'b1;
        bus(1'b0, 8'h00, 0);
        check("rd_out_rst", rdata, 32'h0000_00A5);
        check("rd_out_err", 32'(error), 32'h0);

        // Width truncation
        bus(1'b1, 8'h04, 32'hFFFF_FFFF);
        bus(1'b1, 8'h00, 32'h1234_5678);
        bus(1'b0, 8'h04, 0);
        check("rd_dir", rdata, 32'h0000_FFFF);
        bus(1'b0, 8'h00, 0);
        check("rd_out", rdata, 32'h0000_5678);
        check("gpio_o_val", 32'(gpio_o), 32'h5678);

        // Rising-edge latency, clear, set-beats-clear
        bus(1'b1, 8'h14, 32'h1);
        bus(1'b1, 8'h0C, 32'h1);
        idle(4);
        gpio_i[0] = 1'b1;
        step();
        step();
        check("irq_k1", 32'(irq), 32'h0);
        step();
        check("irq_k2", 32'(irq), 32'h1);
        bus(1'b1, 8'h10, 32'h1);
        check("irq_clr", 32'(irq), 32'h0);
        gpio_i[0] = 1'b0;
        idle(5);
        gpio_i[0] = 1'b1;
        step();
        step();
        bus(1'b1, 8'h10, 32'h1);
        check("irq_setwins", 32'(irq), 32'h1);

        // Mid-access reset drops the response
        resetn = 1'b0; req = 1'b1;
        step();
        req = 1'b0;
        check("rst_mid_rvalid", 32'(rvalid), 32'h0);

        // Pins held high through reset must not raise pending
        gpio_i = 16'hFFFF;
        step();
        resetn = 1'b1;
        bus(1'b1, 8'h14, 32'hFFFF);
        idle(6);
        bus(1'b0, 8'h10, 0);
        check("arm_mask_pend", rdata, 32'h0);

        // Error cases
        bus(1'b1, 8'h08, 32'h0);
        check("wr_ro_err", 32'(error), 32'h1);
        bus(1'b0, 8'h08, 0);
        check("rd_in_kept", rdata, 32'h0000_FFFF);
        bus(1'b0, 8'h02, 0);
        check("misalign_err", 32'(error), 32'h1);
        bus(1'b0, 8'h40, 0);
        check("unmapped_err", 32'(error), 32'h1);
        check("unmapped_rd", rdata, 32'h0);

        // SET/CLR aliases
        bus(1'b1, 8'h00, 32'h00F0);
        bus(1'b1, 8'h18, 32'h000F);
        bus(1'b1, 8'h1C, 32'h0080);
`ifdef GPIO_SET_CLR_EN
        check("clr_err", 32'(error), 32'h0);
        bus(1'b0, 8'h00, 0);
        check("setclr_out", rdata, 32'h007F);
`else
        check("clr_err", 32'(error), 32'h1);
        bus(1'b0, 8'h00, 0);
        check("setclr_out", rdata, 32'h00F0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn = ($urandom_range(0, 255) != 0);
            req    = ($urandom_range(0, 2) != 0);
            we     = $urandom_range(0, 1) == 1;
            addr   = addrs[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wdata  = $urandom;
            if ($urandom_range(0, 3) == 0) gpio_i = gpio_i ^ W'($urandom & $urandom);
            step();
        end
        resetn = 1'b1; req = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
